// File: rtl/aes_ctr_block_sched_if.sv
// Byte/block bus between the CTR block scheduler and its neighbours:
// the UART RX byte receiver, the AES-CTR core and the 128-bit TX serializer.
//
// Handshake semantics: every *_valid / *_enable / *_start / *_done signal is a
// single-cycle strobe. The qualified data is valid only in the cycle the strobe
// is high. There is no ready or backpressure path. A strobe that arrives while
// the receiver is not in the state that consumes it is dropped by the receiver.
interface aes_ctr_block_sched_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         aes_enable;
    logic [127:0] aes_plaintext;
    logic [127:0] aes_nonce;
    logic         aes_valid;
    logic [127:0] aes_ciphertext;
    logic         tx_start;
    logic [127:0] tx_data;
    logic         tx_done;

    // Environment side: byte source, AES core and TX serializer.
    modport master (
        output rx_data, rx_valid, aes_valid, aes_ciphertext, tx_done,
        input  aes_enable, aes_plaintext, aes_nonce, tx_start, tx_data
    );

    // Scheduler side.
    modport slave (
        input  rx_data, rx_valid, aes_valid, aes_ciphertext, tx_done,
        output aes_enable, aes_plaintext, aes_nonce, tx_start, tx_data
    );
endinterface

// File: rtl/aes_ctr_block_sched.sv
// AES-CTR block scheduler. It collects 16 RX bytes into a block (byte 0 is the
// MSB byte), starts the AES core with the current counter block and hands the
// ciphertext to the TX serializer. After transmission it advances the low
// CTR_WIDTH bits of the counter.
// Optional feature macro: AES_CTR_TIMEOUT_EN. When it is defined, the block is
// dropped if aes_valid does not arrive within TIMEOUT_CYCLES cycles.
module aes_ctr_block_sched #(
    parameter int CTR_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       reset,
    aes_ctr_block_sched_if.slave       bus,
    input  logic [127:0]               nonce_base,
    input  logic                       ctr_load,
    output logic                       busy,
    output logic                       overrun,
    output logic                       err_timeout,
    output logic [15:0]                blocks_done,
    output logic [2:0]                 dbg_state,
    output logic [3:0]                 dbg_byte_cnt
);

    typedef enum logic [2:0] {
        S_COLLECT  = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_AES = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_TX  = 3'd4
    } state_t;

    // Only the low CTR_WIDTH bits of the counter block take part in the increment.
    localparam logic [127:0] CTR_MASK = (CTR_WIDTH >= 128) ? {128{1'b1}}
                                        : ((128'd1 << CTR_WIDTH) - 128'd1);

    state_t         state, state_next;
    logic [3:0]     byte_cnt;
    logic [3:0]     byte_idx;
    logic [127:0]   plaintext_r;
    logic [127:0]   nonce_r;
    logic [127:0]   nonce_inc;
    logic [127:0]   tx_data_r;
    logic           load_ok;
    logic           timeout_hit;

    // A load in COLLECT takes effect before a byte in the same cycle.
    // That byte then lands in slot 0.
    assign load_ok   = (state == S_COLLECT) && ctr_load;
    assign byte_idx  = load_ok ? 4'd0 : byte_cnt;
    assign nonce_inc = (nonce_r & ~CTR_MASK) | ((nonce_r + 128'd1) & CTR_MASK);

`ifdef AES_CTR_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              err_timeout_r;

    assign timeout_hit = (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_timeout_r;

    // Wait counter for the AES result and the sticky timeout flag.
    // An aes_valid in the expiry cycle wins over the timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt      <= '0;
            err_timeout_r <= 1'b0;
        end else begin
            if (state == S_WAIT_AES && !bus.aes_valid && !timeout_hit)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (load_ok)
                err_timeout_r <= 1'b0;
            else if (state == S_WAIT_AES && !bus.aes_valid && timeout_hit)
                err_timeout_r <= 1'b1;
        end
    end
`else
    // No wait counter exists in this build. The comparison is never true for a
    // legal (positive) TIMEOUT_CYCLES.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_COLLECT;
        else        state <= state_next;
    end

    // Next-state decode: 16th byte, AES result, TX completion, optional timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_COLLECT:  if (bus.rx_valid && byte_idx == 4'd15) state_next = S_ISSUE;
            S_ISSUE:    state_next = S_WAIT_AES;
            S_WAIT_AES: begin
                if (bus.aes_valid)    state_next = S_SEND;
                else if (timeout_hit) state_next = S_COLLECT;
            end
            S_SEND:     state_next = S_WAIT_TX;
            S_WAIT_TX:  if (bus.tx_done) state_next = S_COLLECT;
            default:    state_next = S_COLLECT;
        endcase
    end

    // Moore output decode from registered state.
    always_comb begin
        bus.aes_enable = (state == S_ISSUE);
        bus.tx_start   = (state == S_SEND);
        busy           = (state != S_COLLECT) || (byte_cnt != 4'd0);
        dbg_state      = state;
        dbg_byte_cnt   = byte_cnt;
    end

    // Datapath: byte assembly, counter block, ciphertext latch, status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt    <= 4'd0;
            plaintext_r <= '0;
            nonce_r     <= '0;
            tx_data_r   <= '0;
            blocks_done <= 16'd0;
            overrun     <= 1'b0;
        end else begin
            if (load_ok) begin
                nonce_r     <= nonce_base;
                blocks_done <= 16'd0;
                overrun     <= 1'b0;
                byte_cnt    <= 4'd0;
            end
            if (state == S_COLLECT && bus.rx_valid) begin
                for (int i = 0; i < 16; i++) begin
                    if (byte_idx == 4'(i)) plaintext_r[8*(15-i) +: 8] <= bus.rx_data;
                end
                byte_cnt <= (byte_idx == 4'd15) ? 4'd0 : byte_idx + 4'd1;
            end
            if (state != S_COLLECT && bus.rx_valid)
                overrun <= 1'b1;
            if (state == S_WAIT_AES && bus.aes_valid)
                tx_data_r <= bus.aes_ciphertext;
            if (state == S_WAIT_TX && bus.tx_done) begin
                nonce_r     <= nonce_inc;
                blocks_done <= blocks_done + 16'd1;
            end
        end
    end

    assign bus.aes_plaintext = plaintext_r;
    assign bus.aes_nonce     = nonce_r;
    assign bus.tx_data       = tx_data_r;

endmodule
